// File: rtl/writeback_unit.sv
// Writeback stage: registers ALU results into the register file and formats
// load data returned by the data memory, with alignment and timeout checking.
module writeback_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_wen,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic [2:0]  in_funct3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        reg_we,
  output logic [4:0]  dstreg_num,
  output logic [31:0] dstreg_data,
  output logic        err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  wait_cnt_r, wait_cnt_s;
  logic [4:0]  ld_rd_r, ld_rd_s;
  logic        ld_wen_r, ld_wen_s;
  logic [2:0]  ld_funct3_r, ld_funct3_s;
  logic [1:0]  ld_addr_r, ld_addr_s;
  logic        reg_we_r, reg_we_s;
  logic [4:0]  dstreg_num_r, dstreg_num_s;
  logic [31:0] dstreg_data_r, dstreg_data_s;
  logic        err_r, err_s;

  // Reserved funct3 encodings fall through to the full-word case.
  function automatic logic [31:0] format_load(input logic [2:0] funct3,
                                              input logic [1:0] addr,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    shifted = word >> {addr, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  return {{24{byte_v[7]}}, byte_v};
      3'b001:  return {{16{half_v[15]}}, half_v};
      3'b100:  return {24'd0, byte_v};
      3'b101:  return {16'd0, half_v};
      default: return word;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr);
    case (funct3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return addr[0];
      default:        return (addr != 2'b00);
    endcase
  endfunction

  assign in_ready    = (state_r != WAIT_MEM);
  assign reg_we      = reg_we_r;
  assign dstreg_num  = dstreg_num_r;
  assign dstreg_data = dstreg_data_r;
  assign err         = err_r;

  // Next-state and next-output logic; write data only changes on an actual write.
  always_comb begin
    state_s       = state_r;
    wait_cnt_s    = wait_cnt_r;
    ld_rd_s       = ld_rd_r;
    ld_wen_s      = ld_wen_r;
    ld_funct3_s   = ld_funct3_r;
    ld_addr_s     = ld_addr_r;
    reg_we_s      = 1'b0;
    dstreg_num_s  = dstreg_num_r;
    dstreg_data_s = dstreg_data_r;
    err_s         = err_r;
    case (state_r)
      IDLE, DRAIN: begin
        if (in_valid && in_is_load) begin
          state_s     = WAIT_MEM;
          wait_cnt_s  = 8'd0;
          ld_rd_s     = in_rd;
          ld_wen_s    = in_wen;
          ld_funct3_s = in_funct3;
          ld_addr_s   = in_result[1:0];
        end else if (in_valid) begin
          state_s = IDLE;
          if (in_wen && (in_rd != 5'd0)) begin
            reg_we_s      = 1'b1;
            dstreg_num_s  = in_rd;
            dstreg_data_s = in_result;
          end else begin
            reg_we_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_s = DRAIN;
          if (is_misaligned(ld_funct3_r, ld_addr_r)) begin
            err_s = 1'b1;
          end else if (ld_wen_r && (ld_rd_r != 5'd0)) begin
            reg_we_s      = 1'b1;
            dstreg_num_s  = ld_rd_r;
            dstreg_data_s = format_load(ld_funct3_r, ld_addr_r, mem_rdata);
          end else begin
            reg_we_s = 1'b0;
          end
        end else if (wait_cnt_r == TIMEOUT_CNT) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          wait_cnt_s = wait_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Load context, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r    <= 8'd0;
      ld_rd_r       <= 5'd0;
      ld_wen_r      <= 1'b0;
      ld_funct3_r   <= 3'd0;
      ld_addr_r     <= 2'd0;
      reg_we_r      <= 1'b0;
      dstreg_num_r  <= 5'd0;
      dstreg_data_r <= 32'd0;
      err_r         <= 1'b0;
    end else begin
      wait_cnt_r    <= wait_cnt_s;
      ld_rd_r       <= ld_rd_s;
      ld_wen_r      <= ld_wen_s;
      ld_funct3_r   <= ld_funct3_s;
      ld_addr_r     <= ld_addr_s;
      reg_we_r      <= reg_we_s;
      dstreg_num_r  <= dstreg_num_s;
      dstreg_data_r <= dstreg_data_s;
      err_r         <= err_s;
    end
  end

endmodule
